// File: rtl/pixel_arbiter.sv
// Merges the player and bee pixel streams into the single VGA write port.
// Each source gets a small FIFO; a round-robin arbiter emits one registered pixel per clock.
module pixel_arbiter #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned X_W   = 7,
  parameter int unsigned Y_W   = 7,
  parameter int unsigned C_W   = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [X_W-1:0] p0_x,
  input  logic [Y_W-1:0] p0_y,
  input  logic [C_W-1:0] p0_color,
  input  logic           p0_write,
  input  logic [X_W-1:0] p1_x,
  input  logic [Y_W-1:0] p1_y,
  input  logic [C_W-1:0] p1_color,
  input  logic           p1_write,
  output logic           p0_full,
  output logic           p1_full,
  output logic           p0_ovf,
  output logic           p1_ovf,
  output logic [X_W-1:0] vga_x,
  output logic [Y_W-1:0] vga_y,
  output logic [C_W-1:0] vga_color,
  output logic           vga_plot
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned EW = X_W + Y_W + C_W;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  logic [EW-1:0] mem0 [DEPTH];
  logic [EW-1:0] mem1 [DEPTH];
  logic [AW-1:0] wr0, rd0, wr1, rd1;
  logic [AW:0]   cnt0, cnt1;
  logic          last;

  logic          ne0, ne1, gnt_any, gnt_sel;
  logic          push0, push1, pop0, pop1;
  logic [EW-1:0] head;

  // Full/empty and arbitration all use the pre-edge counts.
  always_comb begin
    ne0     = (cnt0 != '0);
    ne1     = (cnt1 != '0);
    p0_full = (cnt0 == FULL_CNT);
    p1_full = (cnt1 == FULL_CNT);
    push0   = p0_write && !p0_full;
    push1   = p1_write && !p1_full;
    gnt_any = ne0 || ne1;
    gnt_sel = (ne0 && ne1) ? !last : ne1;
    pop0    = gnt_any && !gnt_sel;
    pop1    = gnt_any && gnt_sel;
    head    = gnt_sel ? mem1[rd1] : mem0[rd0];
  end

  // Storage is deliberately not reset; only pointers and counts are.
  always_ff @(posedge clk) begin
    if (push0) mem0[wr0] <= {p0_x, p0_y, p0_color};
    if (push1) mem1[wr1] <= {p1_x, p1_y, p1_color};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr0       <= '0;
      rd0       <= '0;
      cnt0      <= '0;
      wr1       <= '0;
      rd1       <= '0;
      cnt1      <= '0;
      p0_ovf    <= 1'b0;
      p1_ovf    <= 1'b0;
      last      <= 1'b1;
      vga_x     <= '0;
      vga_y     <= '0;
      vga_color <= '0;
      vga_plot  <= 1'b0;
    end else begin
      if (push0) wr0 <= wr0 + 1'b1;
      if (pop0)  rd0 <= rd0 + 1'b1;
      if (push1) wr1 <= wr1 + 1'b1;
      if (pop1)  rd1 <= rd1 + 1'b1;
      cnt0 <= cnt0 + {{AW{1'b0}}, push0} - {{AW{1'b0}}, pop0};
      cnt1 <= cnt1 + {{AW{1'b0}}, push1} - {{AW{1'b0}}, pop1};
      if (p0_write && p0_full) p0_ovf <= 1'b1;
      if (p1_write && p1_full) p1_ovf <= 1'b1;
      if (gnt_any) begin
        {vga_x, vga_y, vga_color} <= head;
        vga_plot                  <= 1'b1;
        last                      <= gnt_sel;
      end else begin
        vga_plot <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pixel_arbiter.sv
// Randomized bench for pixel_arbiter: a queue-based reference model predicts every plot,
// and a monitor on the falling edge scores the DUT against that prediction.
module tb_pixel_arbiter;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned X_W   = 7;
  localparam int unsigned Y_W   = 7;
  localparam int unsigned C_W   = 3;
  localparam int unsigned EW    = X_W + Y_W + C_W;

  logic           clk = 1'b0;
  logic           reset;
  logic [X_W-1:0] p0_x, p1_x, vga_x;
  logic [Y_W-1:0] p0_y, p1_y, vga_y;
  logic [C_W-1:0] p0_color, p1_color, vga_color;
  logic           p0_write, p1_write;
  logic           p0_full, p1_full, p0_ovf, p1_ovf, vga_plot;

  pixel_arbiter #(.DEPTH(DEPTH), .X_W(X_W), .Y_W(Y_W), .C_W(C_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .p0_x      (p0_x),
    .p0_y      (p0_y),
    .p0_color  (p0_color),
    .p0_write  (p0_write),
    .p1_x      (p1_x),
    .p1_y      (p1_y),
    .p1_color  (p1_color),
    .p1_write  (p1_write),
    .p0_full   (p0_full),
    .p1_full   (p1_full),
    .p0_ovf    (p0_ovf),
    .p1_ovf    (p1_ovf),
    .vga_x     (vga_x),
    .vga_y     (vga_y),
    .vga_color (vga_color),
    .vga_plot  (vga_plot)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  logic [EW-1:0] q0[$];
  logic [EW-1:0] q1[$];
  logic [EW-1:0] sb[$];
  logic [EW-1:0] m_last_pix = '0;
  logic          m_last = 1'b1;
  logic          m_ovf0 = 1'b0;
  logic          m_ovf1 = 1'b0;
  logic          mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: grant from pre-edge occupancy, then accept writes if the pre-edge queue had room.
  initial begin
    int n0, n1;
    logic g;
    logic [EW-1:0] e;
    forever begin
      @(posedge clk);
      if (reset) begin
        q0.delete();
        q1.delete();
        sb.delete();
        m_last = 1'b1;
        m_ovf0 = 1'b0;
        m_ovf1 = 1'b0;
        m_last_pix = '0;
      end else begin
        n0 = q0.size();
        n1 = q1.size();
        if (n0 > 0 || n1 > 0) begin
          g = (n0 > 0 && n1 > 0) ? !m_last : (n1 > 0);
          e = g ? q1.pop_front() : q0.pop_front();
          sb.push_back(e);
          m_last_pix = e;
          m_last = g;
        end
        if (p0_write) begin
          if (n0 < DEPTH) q0.push_back({p0_x, p0_y, p0_color});
          else m_ovf0 = 1'b1;
        end
        if (p1_write) begin
          if (n1 < DEPTH) q1.push_back({p1_x, p1_y, p1_color});
          else m_ovf1 = 1'b1;
        end
      end
    end
  end

  // Monitor: every plot must match the oldest prediction; no plot means outputs hold.
  initial begin
    logic exp_plot;
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        exp_plot = (sb.size() != 0);
        check("plot", {31'd0, vga_plot}, {31'd0, exp_plot});
        if (exp_plot) begin
          e = sb.pop_front();
          check("pixel", {15'd0, vga_x, vga_y, vga_color}, {15'd0, e});
        end else begin
          check("hold", {15'd0, vga_x, vga_y, vga_color}, {15'd0, m_last_pix});
        end
        check("p0_full", {31'd0, p0_full}, {31'd0, q0.size() == DEPTH});
        check("p1_full", {31'd0, p1_full}, {31'd0, q1.size() == DEPTH});
        check("p0_ovf", {31'd0, p0_ovf}, {31'd0, m_ovf0});
        check("p1_ovf", {31'd0, p1_ovf}, {31'd0, m_ovf1});
      end
    end
  end

  task automatic step(input logic w0, input logic w1);
    logic [31:0] r0, r1;
    r0 = $urandom;
    r1 = $urandom;
    p0_x = r0[X_W-1:0];
    p0_y = r0[X_W+Y_W-1:X_W];
    p0_color = r0[EW-1:X_W+Y_W];
    p1_x = r1[X_W-1:0];
    p1_y = r1[X_W+Y_W-1:X_W];
    p1_color = r1[EW-1:X_W+Y_W];
    p0_write = w0;
    p1_write = w1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    step(1'b0, 1'b0);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    p0_write = 1'b0;
    p1_write = 1'b0;
    p0_x = '0; p0_y = '0; p0_color = '0;
    p1_x = '0; p1_y = '0; p1_color = '0;
    @(negedge clk);
    mon_en = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Single pixel with fixed values
    p0_x = 7'd5; p0_y = 7'd9; p0_color = 3'd3; p0_write = 1'b1;
    @(negedge clk);
    p0_write = 1'b0;
    idle(4);

    // Contention straight after reset: p0 must win first
    pulse_reset();
    repeat (3) step(1'b1, 1'b1);
    idle(10);

    // p1 burst of DEPTH+1 drains concurrently, so no overflow
    repeat (DEPTH + 1) step(1'b0, 1'b1);
    idle(15);
    check("no_ovf_burst", {31'd0, p1_ovf}, 32'd0);

    // Both streaming saturates p1 (half bandwidth) until it overflows
    repeat (3 * DEPTH) step(1'b1, 1'b1);
    check("ovf_set", {31'd0, p1_ovf}, 32'd1);
    idle(4 * DEPTH);
    check("ovf_sticky", {31'd0, p1_ovf}, 32'd1);

    // Wrap-around with gaps
    pulse_reset();
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'b0);
      idle($urandom_range(0, 2));
    end
    idle(6);

    // Reset mid-burst flushes both FIFOs
    repeat (5) step(1'b1, 1'b1);
    pulse_reset();
    check("rst_plot", {31'd0, vga_plot}, 32'd0);
    check("rst_pix", {15'd0, vga_x, vga_y, vga_color}, 32'd0);
    idle(1);
    check("rst_empty", {31'd0, vga_plot}, 32'd0);
    repeat (2) step(1'b1, 1'b1);
    idle(10);

    // Random traffic, occasionally oversubscribed
    repeat (400) step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50);
    idle(2 * DEPTH + 10);

    check("sb_drained", sb.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
